// File: rtl/inst_fetch_pkg.sv
// Shared types for the PU fetch stage: address/word/register-index types,
// the freeze point selector for interrupt return PCs and the fetch FSM states.
package inst_fetch_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int INST_W_DEF = 32;
  localparam int REG_IDX_W  = 5;

  typedef logic [ADDR_W_DEF-1:0] address_t;
  typedef logic [INST_W_DEF-1:0] word_t;
  typedef logic [REG_IDX_W-1:0]  reg_index_t;

  // Which pipeline point an interrupt freezes at; selects the return PC.
  typedef enum logic [1:0] {
    FZ_NONE   = 2'd0,
    FZ_FETCH  = 2'd1,
    FZ_DECODE = 2'd2
  } freeze_at_e;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_REFILL = 2'd2,
    ST_WAIT   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_skid.sv
// One-entry skid buffer catching the memory response that lands during the
// first cycle of a hold. Flush wins over push; push wins over pop.
module inst_fetch_skid
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_over,
  input  reg_index_t        in_sel,
  output logic              full,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_over,
  output reg_index_t        out_sel
);

  // Occupancy flag.
  always_ff @(posedge clk) begin
    if (reset || flush) full <= 1'b0;
    else if (push)      full <= 1'b1;
    else if (pop)       full <= 1'b0;
  end

  // Payload; only meaningful while full is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      out_inst <= in_inst;
      out_pc   <= in_pc;
      out_over <= in_over;
      out_sel  <= in_sel;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, fetch FSM, redirect mux, decode-facing
// registers and interrupt return PC capture.
// Optional build macro INST_FETCH_PERF_EN adds saturating perf counters
// perf_fetched and perf_bubbles.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] int_vect,
  input  logic              int_jump,
  input  logic [1:0]        freeze_at,
  input  logic              hold,
  input  logic              if_wait,
  input  logic              gpr_sel_c_over,
  input  reg_index_t        gpr_sel_c,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              sel_c_over,
  output reg_index_t        sel_c,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              waiting
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_seq;
  logic              redirect, go_wait, advance;
  logic              rsp_vld;
  logic [ADDR_W-1:0] rsp_pc;
  freeze_at_e        fz;

  logic              sk_full;
  logic [INST_W-1:0] sk_inst;
  logic [ADDR_W-1:0] sk_pc;
  logic              sk_over;
  reg_index_t        sk_sel;

  assign fz        = freeze_at_e'(freeze_at);
  assign pc_seq    = pc + ADDR_W'(1);
  assign imem_addr = pc;
  assign imem_en   = !reset && (state != ST_WAIT) && !hold;
  assign waiting   = (state == ST_WAIT);

  // Next-state / redirect mux: int_jump > jump > if_wait > hold > sequential.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redirect  = 1'b0;
    go_wait   = 1'b0;
    advance   = 1'b0;
    if (int_jump) begin
      pc_nxt    = int_vect;
      state_nxt = ST_REFILL;
      redirect  = 1'b1;
    end else if (state != ST_WAIT) begin
      if (jump) begin
        pc_nxt    = new_pc;
        state_nxt = ST_REFILL;
        redirect  = 1'b1;
      end else if (if_wait && state == ST_RUN) begin
        state_nxt = ST_WAIT;
        go_wait   = 1'b1;
      end else if (!hold) begin
        pc_nxt    = pc_seq;
        state_nxt = ST_RUN;
        advance   = 1'b1;
      end
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_START;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Tracks the single outstanding request; redirects and wait entry drop it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld <= 1'b0;
      rsp_pc  <= '0;
    end else begin
      rsp_vld <= advance;
      rsp_pc  <= pc;
    end
  end

  inst_fetch_skid #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (hold && rsp_vld && !redirect && !go_wait),
    .pop      (advance && sk_full),
    .flush    (redirect || go_wait),
    .in_inst  (imem_data),
    .in_pc    (rsp_pc),
    .in_over  (gpr_sel_c_over),
    .in_sel   (gpr_sel_c),
    .full     (sk_full),
    .out_inst (sk_inst),
    .out_pc   (sk_pc),
    .out_over (sk_over),
    .out_sel  (sk_sel)
  );

  // Decode-facing registers: skid entry drains before any new response.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      sel_c_over <= 1'b0;
      sel_c      <= '0;
    end else if (redirect || go_wait) begin
      inst_valid <= 1'b0;
    end else if (advance) begin
      if (sk_full) begin
        inst       <= sk_inst;
        inst_pc    <= sk_pc;
        sel_c_over <= sk_over;
        sel_c      <= sk_sel;
        inst_valid <= 1'b1;
      end else if (rsp_vld) begin
        inst       <= imem_data;
        inst_pc    <= rsp_pc;
        sel_c_over <= gpr_sel_c_over;
        sel_c      <= gpr_sel_c;
        inst_valid <= 1'b1;
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

  // Interrupt return PC, chosen by where the interrupt freezes the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_ret_pc <= '0;
    end else if (int_jump) begin
      case (fz)
        FZ_FETCH:  int_ret_pc <= rsp_pc;
        FZ_DECODE: int_ret_pc <= inst_pc;
        default:   int_ret_pc <= pc_seq;
      endcase
    end
  end

`ifdef INST_FETCH_PERF_EN
  // Saturating count of instructions accepted by decode.
  always_ff @(posedge clk) begin
    if (reset)
      perf_fetched <= '0;
    else if (inst_valid && !hold && perf_fetched != '1)
      perf_fetched <= perf_fetched + 32'd1;
  end

  // Saturating count of refill and wait bubbles.
  always_ff @(posedge clk) begin
    if (reset)
      perf_bubbles <= '0;
    else if ((state == ST_REFILL || state == ST_WAIT) && perf_bubbles != '1)
      perf_bubbles <= perf_bubbles + 32'd1;
  end
`endif

endmodule
